// File: rtl/dcache_pkg.sv
// Shared types and address-field helpers for the direct-mapped data cache.
// Line = 4 x 32-bit words = one 128-bit memory beat.
package dcache_pkg;
    localparam int DC_NUM_LINES   = 64;
    localparam int WORDS_PER_LINE = 4;
    localparam int OFFSET_W       = 2;
    localparam int INDEX_W        = $clog2(DC_NUM_LINES);
    localparam int TAG_W          = 32 - INDEX_W - OFFSET_W - 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WRITE_THRU
    } state_t;

    function automatic logic [31:0] line_addr(input logic [31:0] a);
        return {a[31:4], 4'b0000};
    endfunction

    function automatic logic [31:0] word_addr(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

    function automatic logic [OFFSET_W-1:0] word_sel(input logic [31:0] a);
        return a[3:2];
    endfunction
endpackage

// File: rtl/dcache_tag_data_array.sv
// Valid/tag/data storage for the data cache: combinational read of the indexed line,
// synchronous whole-line fill, synchronous single-word write, valid bits cleared on reset.
module dcache_tag_data_array
    import dcache_pkg::*;
#(
    parameter int NUM_LINES = DC_NUM_LINES,
    parameter int IDX_W     = INDEX_W,
    parameter int TAG_BITS  = TAG_W
) (
    input  logic                clock,
    input  logic                resetN,
    input  logic [IDX_W-1:0]    i_index,
    output logic                o_rd_valid,
    output logic [TAG_BITS-1:0] o_rd_tag,
    output logic [127:0]        o_rd_line,
    input  logic                i_fill_en,
    input  logic [TAG_BITS-1:0] i_fill_tag,
    input  logic [127:0]        i_fill_line,
    input  logic                i_wr_en,
    input  logic [OFFSET_W-1:0] i_wr_word,
    input  logic [31:0]         i_wr_data
);
    logic [NUM_LINES-1:0] r_valid;
    logic [TAG_BITS-1:0]  r_tag [NUM_LINES];

    always_ff @(posedge clock) begin
        if (!resetN) begin
            r_valid <= '0;
        end else if (i_fill_en) begin
            r_valid[i_index] <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (i_fill_en) begin
            r_tag[i_index] <= i_fill_tag;
        end
    end

    assign o_rd_valid = r_valid[i_index];
    assign o_rd_tag   = r_tag[i_index];

    // One storage column per word so a store touches only its own word.
    for (genvar gi = 0; gi < WORDS_PER_LINE; gi++) begin : g_word
        logic [31:0] r_mem [NUM_LINES];

        always_ff @(posedge clock) begin
            if (i_fill_en) begin
                r_mem[i_index] <= i_fill_line[gi*32 +: 32];
            end else if (i_wr_en && (i_wr_word == OFFSET_W'(gi))) begin
                r_mem[i_index] <= i_wr_data;
            end
        end

        assign o_rd_line[gi*32 +: 32] = r_mem[i_index];
    end
endmodule

// File: rtl/data_cache_controller.sv
// Direct-mapped, write-through, no-write-allocate data cache controller for the MEM stage.
// Optional DCACHE_STATS_EN adds readHitCount/readMissCount statistics ports.
module data_cache_controller
    import dcache_pkg::*;
#(
    parameter int NUM_LINES = DC_NUM_LINES
) (
    input  logic         clock,
    input  logic         resetN,
    input  logic         memRead,
    input  logic         memWrite,
    input  logic [31:0]  address,
    input  logic [31:0]  writeData,
    output logic [31:0]  readData,
    output logic         hit,
    output logic         memReq,
    output logic         memWe,
    output logic [31:0]  memAddr,
    output logic [31:0]  memWdata,
    input  logic [127:0] memRdata,
    input  logic         memReady
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]  readHitCount,
    output logic [31:0]  readMissCount
`endif
);
    localparam int IDX_W    = $clog2(NUM_LINES);
    localparam int TAG_BITS = 32 - 4 - IDX_W;

    state_t r_state;

    logic [IDX_W-1:0]    w_index;
    logic [TAG_BITS-1:0] w_tag;
    logic [OFFSET_W-1:0] w_offset;
    logic                w_rd_valid;
    logic [TAG_BITS-1:0] w_rd_tag;
    logic [127:0]        w_rd_line;
    logic                w_tag_match;
    logic                w_is_read;
    logic                w_read_hit;
    logic                w_fill_en;
    logic                w_wr_en;
    logic                w_unused_ok;

    assign w_index     = address[4 +: IDX_W];
    assign w_tag       = address[31 -: TAG_BITS];
    assign w_offset    = word_sel(address);
    assign w_unused_ok = &{1'b0, address[1:0]};

    assign w_tag_match = w_rd_valid && (w_rd_tag == w_tag);
    // A simultaneous read+write is handled as a write.
    assign w_is_read   = memRead && !memWrite;
    assign w_read_hit  = (r_state == ST_IDLE) && w_is_read && w_tag_match;
    assign w_fill_en   = (r_state == ST_FETCH) && memReady && resetN;
    assign w_wr_en     = (r_state == ST_WRITE_THRU) && memReady && w_tag_match && resetN;

    dcache_tag_data_array #(
        .NUM_LINES (NUM_LINES),
        .IDX_W     (IDX_W),
        .TAG_BITS  (TAG_BITS)
    ) u_array (
        .clock       (clock),
        .resetN      (resetN),
        .i_index     (w_index),
        .o_rd_valid  (w_rd_valid),
        .o_rd_tag    (w_rd_tag),
        .o_rd_line   (w_rd_line),
        .i_fill_en   (w_fill_en),
        .i_fill_tag  (w_tag),
        .i_fill_line (memRdata),
        .i_wr_en     (w_wr_en),
        .i_wr_word   (w_offset),
        .i_wr_data   (writeData)
    );

    assign readData = w_read_hit ? w_rd_line[{w_offset, 5'b00000} +: 32] : 32'h0;

    always_comb begin
        hit = 1'b0;
        case (r_state)
            ST_IDLE:       hit = !memWrite && (!memRead || w_tag_match);
            ST_FETCH:      hit = 1'b0;
            ST_WRITE_THRU: hit = memReady;
            default:       hit = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetN) begin
            r_state  <= ST_IDLE;
            memReq   <= 1'b0;
            memWe    <= 1'b0;
            memAddr  <= 32'h0;
            memWdata <= 32'h0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (memWrite) begin
                        r_state  <= ST_WRITE_THRU;
                        memReq   <= 1'b1;
                        memWe    <= 1'b1;
                        memAddr  <= word_addr(address);
                        memWdata <= writeData;
                    end else if (memRead && !w_tag_match) begin
                        r_state <= ST_FETCH;
                        memReq  <= 1'b1;
                        memWe   <= 1'b0;
                        memAddr <= line_addr(address);
                    end
                end
                ST_FETCH, ST_WRITE_THRU: begin
                    if (memReady) begin
                        r_state <= ST_IDLE;
                        memReq  <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef DCACHE_STATS_EN
    logic        r_after_fill;
    logic [31:0] r_hit_cnt;
    logic [31:0] r_miss_cnt;

    // The retried access right after a refill is already counted as a miss.
    always_ff @(posedge clock) begin
        if (!resetN) begin
            r_after_fill <= 1'b0;
            r_hit_cnt    <= 32'h0;
            r_miss_cnt   <= 32'h0;
        end else begin
            r_after_fill <= w_fill_en;
            if ((r_state == ST_IDLE) && w_is_read && !w_tag_match) begin
                r_miss_cnt <= r_miss_cnt + 32'd1;
            end
            if (w_read_hit && !r_after_fill) begin
                r_hit_cnt <= r_hit_cnt + 32'd1;
            end
        end
    end

    assign readHitCount  = r_hit_cnt;
    assign readMissCount = r_miss_cnt;
`endif
endmodule

// File: tb/tb_data_cache_controller.sv
// Self-checking bench for data_cache_controller: directed scenarios followed by random
// loads/stores checked against an array-based model of the cache and main memory.
module tb_data_cache_controller;
    logic         clock = 1'b0;
    logic         resetN;
    logic         memRead;
    logic         memWrite;
    logic [31:0]  address;
    logic [31:0]  writeData;
    logic [31:0]  readData;
    logic         hit;
    logic         memReq;
    logic         memWe;
    logic [31:0]  memAddr;
    logic [31:0]  memWdata;
    logic [127:0] memRdata;
    logic         memReady;

    int checks = 0;
    int errors = 0;
    int wr_ops = 0;

    // Reference model: cache contents and main memory (word-addressed, sparse).
    bit          m_valid [64];
    logic [21:0] m_tag   [64];
    logic [31:0] m_line  [64][4];
    logic [31:0] mem     [bit [31:0]];

    always #5 clock = ~clock;

    data_cache_controller dut (
        .clock     (clock),
        .resetN    (resetN),
        .memRead   (memRead),
        .memWrite  (memWrite),
        .address   (address),
        .writeData (writeData),
        .readData  (readData),
        .hit       (hit),
        .memReq    (memReq),
        .memWe     (memWe),
        .memAddr   (memAddr),
        .memWdata  (memWdata),
        .memRdata  (memRdata),
        .memReady  (memReady)
    );

    always @(posedge clock) begin
        if (resetN && memReq && memWe && memReady) wr_ops++;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        bit [31:0] w;
        w = {a[31:2], 2'b00};
        if (mem.exists(w)) return mem[w];
        return w * 32'h9E37_79B1 + 32'h1234_5678;
    endfunction

    function automatic bit model_hit(input logic [31:0] a);
        return m_valid[a[9:4]] && (m_tag[a[9:4]] == a[31:10]);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic do_idle();
        memRead  = 1'b0;
        memWrite = 1'b0;
        #1;
        chk("idle_hit", 32'(hit), 32'd1);
        chk("idle_rdata", readData, 32'h0);
        chk("idle_noreq", 32'(memReq), 32'd0);
        $display("TXN idle");
        step();
    endtask

    task automatic do_read(input logic [31:0] a, input int lat, output bit first_hit);
        logic [31:0]  la;
        logic [127:0] line;
        int           idx;
        idx = int'(a[9:4]);
        la  = {a[31:4], 4'b0000};
        memRead  = 1'b1;
        memWrite = 1'b0;
        address  = a;
        #1;
        first_hit = hit;
        if (model_hit(a)) begin
            chk("rd_hit", 32'(hit), 32'd1);
            chk("rd_data", readData, m_line[idx][a[3:2]]);
            chk("rd_noreq", 32'(memReq), 32'd0);
        end else begin
            chk("rd_miss", 32'(hit), 32'd0);
            step();
            #1;
            chk("fetch_req", 32'(memReq), 32'd1);
            chk("fetch_we", 32'(memWe), 32'd0);
            chk("fetch_addr", memAddr, la);
            chk("fetch_stall", 32'(hit), 32'd0);
            repeat (lat) begin
                step();
                #1;
                chk("fetch_wait_stall", 32'(hit), 32'd0);
                chk("fetch_wait_req", 32'(memReq), 32'd1);
            end
            for (int k = 0; k < 4; k++) line[k*32 +: 32] = mem_word(la + 32'(k * 4));
            memReady = 1'b1;
            memRdata = line;
            step();
            memReady = 1'b0;
            memRdata = {$urandom, $urandom, $urandom, $urandom};
            m_valid[idx] = 1'b1;
            m_tag[idx]   = a[31:10];
            for (int k = 0; k < 4; k++) m_line[idx][k] = line[k*32 +: 32];
            #1;
            chk("refill_hit", 32'(hit), 32'd1);
            chk("refill_data", readData, m_line[idx][a[3:2]]);
            chk("refill_req_drop", 32'(memReq), 32'd0);
        end
        $display("TXN read addr=%h lat=%0d first_hit=%0b data=%h", a, lat, first_hit, readData);
        step();
        memRead = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input int lat, input bit both);
        int ops_before;
        bit cached;
        ops_before = wr_ops;
        cached     = model_hit(a);
        memWrite   = 1'b1;
        memRead    = both;
        address    = a;
        writeData  = d;
        #1;
        chk("wr_stall", 32'(hit), 32'd0);
        step();
        #1;
        chk("wt_req", 32'(memReq), 32'd1);
        chk("wt_we", 32'(memWe), 32'd1);
        chk("wt_addr", memAddr, {a[31:2], 2'b00});
        chk("wt_data", memWdata, d);
        chk("wt_stall", 32'(hit), 32'd0);
        repeat (lat) begin
            step();
            #1;
            chk("wt_wait_stall", 32'(hit), 32'd0);
            chk("wt_wait_req", 32'(memReq), 32'd1);
        end
        memReady = 1'b1;
        #1;
        chk("wt_done_hit", 32'(hit), 32'd1);
        step();
        memReady = 1'b0;
        memWrite = 1'b0;
        memRead  = 1'b0;
        mem[{a[31:2], 2'b00}] = d;
        if (cached) m_line[a[9:4]][a[3:2]] = d;
        #1;
        chk("wt_req_drop", 32'(memReq), 32'd0);
        chk("wt_one_write", 32'(wr_ops - ops_before), 32'd1);
        $display("TXN write addr=%h data=%h lat=%0d cached=%0b both=%0b", a, d, lat, cached, both);
    endtask

    initial begin
        bit          h;
        logic [31:0] a;
        int          op;

        resetN    = 1'b0;
        memRead   = 1'b0;
        memWrite  = 1'b0;
        address   = 32'h0;
        writeData = 32'h0;
        memReady  = 1'b0;
        memRdata  = 128'h0;
        repeat (3) step();
        #1;
        chk("rst_hit", 32'(hit), 32'd1);
        chk("rst_req", 32'(memReq), 32'd0);
        chk("rst_we", 32'(memWe), 32'd0);
        chk("rst_addr", memAddr, 32'h0);
        chk("rst_wdata", memWdata, 32'h0);
        chk("rst_rdata", readData, 32'h0);
        resetN = 1'b1;
        step();

        // 1: cold miss on 0x40, memory answers after 3 cycles
        do_read(32'h0000_0040, 3, h);
        chk("t1_first_miss", 32'(h), 32'd0);
        // 2: neighbouring word of the same line hits with no stall
        do_read(32'h0000_0044, 0, h);
        chk("t2_hit", 32'(h), 32'd1);
        // 3: store to cached line updates memory and cache
        do_write(32'h0000_0048, 32'hDEAD_BEEF, 2, 1'b0);
        do_read(32'h0000_0048, 0, h);
        chk("t3_hit", 32'(h), 32'd1);
        chk("t3_model", m_line[4][2], 32'hDEAD_BEEF);
        // 4: store to uncached address does not allocate
        do_write(32'h0000_1000, 32'h1357_9BDF, 1, 1'b0);
        do_read(32'h0000_1000, 1, h);
        chk("t4_no_alloc", 32'(h), 32'd0);
        // 5: conflicting lines on the same index evict each other
        do_read(32'h0000_0440, 0, h);
        chk("t5_conflict_a", 32'(h), 32'd0);
        do_read(32'h0000_0040, 2, h);
        chk("t5_conflict_b", 32'(h), 32'd0);
        do_read(32'h0000_0440, 1, h);
        chk("t5_conflict_c", 32'(h), 32'd0);
        do_idle();
        // 6: reset in the middle of a fetch abandons it
        memRead = 1'b1;
        address = 32'h0000_0840;
        #1;
        chk("t6_miss", 32'(hit), 32'd0);
        step();
        #1;
        chk("t6_fetch_req", 32'(memReq), 32'd1);
        memRead = 1'b0;
        resetN  = 1'b0;
        step();
        #1;
        chk("t6_req_cleared", 32'(memReq), 32'd0);
        resetN   = 1'b1;
        memReady = 1'b1;
        memRdata = {$urandom, $urandom, $urandom, $urandom};
        step();
        memReady = 1'b0;
        #1;
        chk("t6_late_ready_req", 32'(memReq), 32'd0);
        chk("t6_late_ready_hit", 32'(hit), 32'd1);
        for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
        $display("TXN reset during fetch");
        do_read(32'h0000_0040, 0, h);
        chk("t6_after_reset_miss", 32'(h), 32'd0);

        // Random mix on a small address pool so hits, misses and conflicts all occur.
        for (int n = 0; n < 250; n++) begin
            a = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 7)) << 4)
              | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
            op = $urandom_range(0, 9);
            if (op < 6)       do_read(a, $urandom_range(0, 3), h);
            else if (op < 9)  do_write(a, $urandom, $urandom_range(0, 3), (op == 8));
            else              do_idle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
